stream_demux: RTL

//  Registered 1-to-N stream demultiplexer; the distribution-side counterpart of the 2-input mux.

---
 rtl/stream_demux.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Registered 1-to-N_OUT valid/ready stream demultiplexer. A packet's first
// beat selects its destination through in_sel. That destination is then held
// until the packet's last beat. Each output channel has a one-entry register,
// so an accepted beat appears on its channel on the following clock, and a
// channel can take a new beat every clock as long as its sink keeps up.
//
// Packets whose first-beat in_sel is not a valid channel code (>= N_OUT) are
// accepted and discarded beat by beat. Each discarded packet increments a
// saturating drop counter once.
//
// Parameters
//   N_OUT   number of output channels (2..16)
//   DATA_W  payload width
//   SEL_W   width of in_sel (>= clog2(N_OUT)); codes >= N_OUT are invalid
//   CNT_W   width of drop_count
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_data     input payload
//   in_valid    input beat present
//   in_last     input beat is the final beat of its packet
//   in_sel      destination channel, sampled on a packet's first beat only
//   in_ready    input beat accepted when in_valid & in_ready (combinational)
//   out_data    channel k payload at [k*DATA_W +: DATA_W]
//   out_valid   channel k beat present
//   out_last    channel k final-beat flag
//   out_ready   channel k sink accepts beat
//   drop_count  packets discarded for an invalid in_sel, saturating
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    output logic [N_OUT-1:0]        out_last,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]        drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Saturating increment used by the drop counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t                  state;
    logic [SEL_W-1:0]        dest;       // locked destination while in ROUTE/DROP
    logic [CNT_W-1:0]        drops;

    logic [SEL_W-1:0]        cur_sel;    // destination that applies to the current beat
    logic [N_OUT-1:0]        hit;        // one-hot decode of cur_sel, all zero if invalid
    logic                    sel_ok;
    logic                    chan_free;  // targeted channel can take a beat this cycle
    logic                    accept;
    logic                    to_chan;    // accepted beat is routed rather than dropped
    logic [N_OUT-1:0]        load;
    logic [N_OUT-1:0]        drain;

    logic [N_OUT*DATA_W-1:0] data_p1;
    logic [N_OUT-1:0]        last_p1;
    logic [N_OUT-1:0]        vld_p1;

    // Input decode and handshake. in_sel only matters between packets. Once
    // a packet is in progress, the registered destination drives all
    // routing and ready decisions.
    always_comb begin
        cur_sel = (state == IDLE) ? in_sel : dest;

        hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit[k] = (cur_sel == SEL_W'(k));
        end
        sel_ok = |hit;

        // A channel register can accept when it is empty, or when its current
        // beat leaves in this same cycle.
        chan_free = |(hit & (~vld_p1 | out_ready));

        case (state)
            IDLE:    in_ready = sel_ok ? chan_free : 1'b1;
            ROUTE:   in_ready = chan_free;
            default: in_ready = 1'b1;
        endcase

        accept  = in_valid & in_ready;
        to_chan = accept & ((state == ROUTE) | ((state == IDLE) & sel_ok));
        load    = hit & {N_OUT{to_chan}};
        // A load in the same cycle wins over a drain. The new beat replaces
        // the old one, and valid stays high.
        drain   = vld_p1 & out_ready & ~load;
    end

    // Packet framing FSM and drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            dest  <= '0;
            drops <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    dest <= in_sel;
                    if (sel_ok) begin
                        state <= in_last ? IDLE : ROUTE;
                    end else begin
                        state <= in_last ? IDLE : DROP;
                        drops <= sat_inc(drops);
                    end
                end
                ROUTE, DROP: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: per-channel output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            last_p1 <= '0;
            data_p1 <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    vld_p1[k]                   <= 1'b1;
                    last_p1[k]                  <= in_last;
                    data_p1[k*DATA_W +: DATA_W] <= in_data;
                end else if (drain[k]) begin
                    // Payload is left in place after a drain; only valid drops.
                    vld_p1[k] <= 1'b0;
                end
            end
        end
    end

    assign out_data   = data_p1;
    assign out_last   = last_p1;
    assign out_valid  = vld_p1;
    assign drop_count = drops;

endmodule
